// File: rtl/channel_dump_latch.sv
// Per-channel shadow latch. It captures correlator dumps and TIC measurements and
// serves them, with sticky status flags, through a one-cycle registered read port.
module channel_dump_latch #(
   parameter int DW     = 16,
   parameter int MISS_W = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          dump,
   input  logic          tic_enable,
   input  logic [DW-1:0] i_early,
   input  logic [DW-1:0] q_early,
   input  logic [DW-1:0] i_prompt,
   input  logic [DW-1:0] q_prompt,
   input  logic [DW-1:0] i_late,
   input  logic [DW-1:0] q_late,
   input  logic [31:0]   carrier_val,
   input  logic [20:0]   code_val,
   input  logic [10:0]   epoch,
   input  logic          rd_en,
   input  logic [3:0]    rd_addr,
   input  logic          irq_en,
   output logic [31:0]   rd_data,
   output logic          rd_valid,
   output logic          new_data,
   output logic          irq
);

   localparam logic [MISS_W-1:0] MISS_MAX = '1;
   localparam logic [3:0]        STATUS_ADDR = 4'd6;

   logic signed [DW-1:0] accum_in   [6];
   logic signed [DW-1:0] shadow_reg [6];
   logic [31:0]          word       [16];

   logic              dump_d_reg;
   logic              new_data_reg, new_data_next;
   logic              meas_valid_reg, meas_valid_next;
   logic [MISS_W-1:0] missed_cnt_reg, missed_cnt_next;
   logic [31:0]       carrier_reg;
   logic [20:0]       code_reg;
   logic [10:0]       epoch_reg;
   logic [31:0]       rd_data_reg;
   logic              rd_valid_reg;

   logic capture;
   logic miss;
   logic status_rd;

   assign accum_in[0] = i_early;
   assign accum_in[1] = q_early;
   assign accum_in[2] = i_prompt;
   assign accum_in[3] = q_prompt;
   assign accum_in[4] = i_late;
   assign accum_in[5] = q_late;

   // The channel presents fresh accumulations one cycle after its dump pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) dump_d_reg <= 1'b0;
      else     dump_d_reg <= dump;
   end

   assign capture   = dump_d_reg;
   assign miss      = capture & new_data_reg;
   assign status_rd = rd_en & (rd_addr == STATUS_ADDR);

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_shadow
         always_ff @(posedge clk or posedge rst) begin
            if (rst)          shadow_reg[gi] <= '0;
            else if (capture) shadow_reg[gi] <= accum_in[gi];
         end
         assign word[gi] = 32'(shadow_reg[gi]);
      end
      for (gi = 10; gi < 16; gi++) begin : g_unmapped
         assign word[gi] = 32'd0;
      end
   endgenerate

   assign word[6] = 32'({missed_cnt_reg, meas_valid_reg, new_data_reg});
   assign word[7] = carrier_reg;
   assign word[8] = 32'(code_reg);
   assign word[9] = 32'(epoch_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carrier_reg <= '0;
         code_reg    <= '0;
         epoch_reg   <= '0;
      end else if (tic_enable) begin
         carrier_reg <= carrier_val;
         code_reg    <= code_val;
         epoch_reg   <= epoch;
      end
   end

   // A status read clears the flags, but a capture or TIC on the same edge wins.
   always_comb begin
      new_data_next   = new_data_reg;
      meas_valid_next = meas_valid_reg;
      missed_cnt_next = missed_cnt_reg;
      if (status_rd) begin
         new_data_next   = 1'b0;
         meas_valid_next = 1'b0;
         missed_cnt_next = '0;
      end
      if (capture) new_data_next = 1'b1;
      if (tic_enable) meas_valid_next = 1'b1;
      if (miss) begin
         if (status_rd)                        missed_cnt_next = MISS_W'(1);
         else if (missed_cnt_reg != MISS_MAX)  missed_cnt_next = missed_cnt_reg + MISS_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         new_data_reg   <= 1'b0;
         meas_valid_reg <= 1'b0;
         missed_cnt_reg <= '0;
      end else begin
         new_data_reg   <= new_data_next;
         meas_valid_reg <= meas_valid_next;
         missed_cnt_reg <= missed_cnt_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_en;
         if (rd_en) rd_data_reg <= word[rd_addr];
      end
   end

   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;
   assign new_data = new_data_reg;
   assign irq      = new_data_reg & irq_en;

endmodule
